// File: rtl/cpu_exc_defs.sv
// Exception codes and arbiter FSM state encodings, shared with cp0.
package cpu_exc_defs;

  localparam logic [4:0] EX_CODE_INT    = 5'h00;
  localparam logic [4:0] EX_CODE_HLT    = 5'h01;
  localparam logic [4:0] EX_CODE_RESUME = 5'h02;
  localparam logic [4:0] EX_CODE_ADEL   = 5'h04;
  localparam logic [4:0] EX_CODE_ADES   = 5'h05;
  localparam logic [4:0] EX_CODE_SYS    = 5'h08;
  localparam logic [4:0] EX_CODE_BP     = 5'h09;
  localparam logic [4:0] EX_CODE_RI     = 5'h0a;
  localparam logic [4:0] EX_CODE_OF     = 5'h0c;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BLOCK = 2'd1,
    ST_HALT  = 2'd2
  } exc_state_e;

  function automatic logic exc_is_halt(input logic [4:0] code);
    return code == EX_CODE_HLT;
  endfunction

endpackage

// File: rtl/int_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous interrupt lines.
// Only compiled when EXC_INT_SYNC_EN is defined.
`ifdef EXC_INT_SYNC_EN
module int_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule
`endif

// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter ahead of cp0: one registered, prioritised event per cycle.
// Define EXC_INT_SYNC_EN to route int_hw_in through a 2-flop synchronizer.
module exc_arbiter
  import cpu_exc_defs::*;
#(
  parameter int HOLDOFF_CYCLES = 3,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic        wb_exc_valid,
  input  logic [4:0]  wb_exc_code,
  input  logic        wb_eret,
  input  logic [5:0]  int_hw_in,
  input  logic [1:0]  int_sw,
  input  logic        ie,
  input  logic        exl,
  input  logic [7:0]  int_mask,
  output logic [5:0]  int_hw_out,
  output logic        ex_wb,
  output logic [4:0]  ex_code,
  output logic [31:0] epc,
  output logic        bd,
  output logic        eret_flush,
  output logic        halted
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);

  exc_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_wb_q, ex_wb_d;
  logic [4:0]        ex_code_q, ex_code_d;
  logic [31:0]       epc_q, epc_d;
  logic              bd_q, bd_d;
  logic              eret_flush_q, eret_flush_d;
  logic              halted_q, halted_d;
  logic [5:0]        int_hw_q;
  logic              int_req;
  logic              int_take;

`ifdef EXC_INT_SYNC_EN
  int_sync #(.W(6)) u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_hw_in),
    .q     (int_hw_q)
  );
`else
  always_ff @(posedge clk) begin
    if (!rst_n) int_hw_q <= '0;
    else        int_hw_q <= int_hw_in;
  end
`endif

  assign int_req  = |({int_hw_q, int_sw} & int_mask);
  assign int_take = int_req & ie & ~exl & wb_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_wb_d      = 1'b0;
    eret_flush_d = 1'b0;
    ex_code_d    = ex_code_q;
    epc_d        = epc_q;
    bd_d         = bd_q;

    case (state_q)
      ST_RUN: begin
        if (wb_valid && wb_exc_valid) begin
          ex_wb_d   = 1'b1;
          ex_code_d = wb_exc_code;
          epc_d     = wb_pc;
          bd_d      = wb_bd;
          if (exc_is_halt(wb_exc_code)) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_BLOCK;
            cnt_d   = HOLD_LOAD;
          end
        end else if (int_take) begin
          // Interrupt preempts the WB instruction, so its PC becomes epc.
          ex_wb_d   = 1'b1;
          ex_code_d = EX_CODE_INT;
          epc_d     = wb_pc;
          bd_d      = wb_bd;
          state_d   = ST_BLOCK;
          cnt_d     = HOLD_LOAD;
        end else if (wb_valid && wb_eret) begin
          eret_flush_d = 1'b1;
          state_d      = ST_BLOCK;
          cnt_d        = HOLD_LOAD;
        end
      end

      ST_BLOCK: begin
        // Leave as the count reaches zero; a zero count never wraps.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_HALT: begin
        if (int_req) begin
          ex_wb_d   = 1'b1;
          ex_code_d = EX_CODE_RESUME;
          state_d   = ST_BLOCK;
          cnt_d     = HOLD_LOAD;
        end
      end

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      ex_wb_q      <= 1'b0;
      ex_code_q    <= '0;
      epc_q        <= '0;
      bd_q         <= 1'b0;
      eret_flush_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_wb_q      <= ex_wb_d;
      ex_code_q    <= ex_code_d;
      epc_q        <= epc_d;
      bd_q         <= bd_d;
      eret_flush_q <= eret_flush_d;
      halted_q     <= halted_d;
    end
  end

  assign int_hw_out = int_hw_q;
  assign ex_wb      = ex_wb_q;
  assign ex_code    = ex_code_q;
  assign epc        = epc_q;
  assign bd         = bd_q;
  assign eret_flush = eret_flush_q;
  assign halted     = halted_q;

endmodule
